// File: rtl/vga_draw_pkg.sv
// Shared widths, screen limits and FSM states for the VGA drawing blocks.
package vga_draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic int unsigned xw_of(input bit lowres);
    return lowres ? 32'd8 : 32'd9;
  endfunction

  function automatic int unsigned yw_of(input bit lowres);
    return lowres ? 32'd7 : 32'd8;
  endfunction

  function automatic int unsigned screen_w_of(input bit lowres);
    return lowres ? 32'd160 : 32'd320;
  endfunction

  function automatic int unsigned screen_h_of(input bit lowres);
    return lowres ? 32'd120 : 32'd240;
  endfunction

  function automatic int unsigned cw_of(input bit mono, input int unsigned bits_per_channel);
    return mono ? 32'd1 : 32'(3 * bits_per_channel);
  endfunction

endpackage

// File: rtl/vga_rect_counter.sv
// Row-major col/row sweep counter bounded by a w x h rectangle; flags the last pixel.
module vga_rect_counter #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [XW-1:0] w_i,
  input  logic [YW-1:0] h_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [XW-1:0] col_o,
  output logic [YW-1:0] row_o,
  output logic          last_o
);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic          col_end_c;

  assign col_end_c = (col_q == (w_i - XW'(1)));
  assign last_o    = col_end_c && (row_q == (h_i - YW'(1)));
  assign col_o     = col_q;
  assign row_o     = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (col_end_c) begin
        col_d = '0;
        row_d = row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/vga_rect_plotter.sv
// Rectangle-fill initiator: sweeps one accepted command onto the adapter write port, one pixel per clock.
// Define VGA_RECT_CLIP_EN to suppress plot for off-screen pixels instead of letting coordinates wrap.
module vga_rect_plotter
  import vga_draw_pkg::*;
#(
  parameter string       RESOLUTION              = "320x240",
  parameter int unsigned BITS_PER_COLOUR_CHANNEL = 1,
  parameter string       MONOCHROME              = "FALSE",
  localparam bit          LOWRES = (RESOLUTION == "160x120"),
  localparam int unsigned XW     = xw_of(LOWRES),
  localparam int unsigned YW     = yw_of(LOWRES),
  localparam int unsigned CW     = cw_of(MONOCHROME == "TRUE", BITS_PER_COLOUR_CHANNEL)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic [XW-1:0] req_w,
  input  logic [YW-1:0] req_h,
  input  logic [CW-1:0] req_colour,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [XW-1:0] base_x_q, base_x_d;
  logic [YW-1:0] base_y_q, base_y_d;
  logic [XW-1:0] w_q, w_d;
  logic [YW-1:0] h_q, h_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          clear_c, advance_c, last_c;
  logic [XW-1:0] col_c;
  logic [YW-1:0] row_c;
  logic [XW-1:0] x_pix_c;
  logic [YW-1:0] y_pix_c;
  logic          on_screen_c;

  vga_rect_counter #(
    .XW (XW),
    .YW (YW)
  ) u_counter (
    .clock     (clock),
    .resetn    (resetn),
    .w_i       (w_q),
    .h_i       (h_q),
    .clear_i   (clear_c),
    .advance_i (advance_c),
    .col_o     (col_c),
    .row_o     (row_c),
    .last_o    (last_c)
  );

`ifdef VGA_RECT_CLIP_EN
  // Keep the carry so pixels past the screen edge can be recognised before truncation.
  localparam int unsigned SCREEN_W = screen_w_of(LOWRES);
  localparam int unsigned SCREEN_H = screen_h_of(LOWRES);
  logic [XW:0] x_sum_c;
  logic [YW:0] y_sum_c;
  assign x_sum_c     = {1'b0, base_x_q} + {1'b0, col_c};
  assign y_sum_c     = {1'b0, base_y_q} + {1'b0, row_c};
  assign x_pix_c     = x_sum_c[XW-1:0];
  assign y_pix_c     = y_sum_c[YW-1:0];
  assign on_screen_c = (x_sum_c < (XW+1)'(SCREEN_W)) && (y_sum_c < (YW+1)'(SCREEN_H));
`else
  assign x_pix_c     = base_x_q + col_c;
  assign y_pix_c     = base_y_q + row_c;
  assign on_screen_c = 1'b1;
`endif

  assign req_ready = (state_q == IDLE);
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    base_x_d  = base_x_q;
    base_y_d  = base_y_q;
    w_d       = w_q;
    h_d       = h_q;
    fill_d    = fill_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    clear_c   = 1'b0;
    advance_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_x_d = req_x;
          base_y_d = req_y;
          w_d      = req_w;
          h_d      = req_h;
          fill_d   = req_colour;
          clear_c  = 1'b1;
          state_d  = ((req_w != '0) && (req_h != '0)) ? DRAW : FIN;
        end
      end
      DRAW: begin
        x_d      = x_pix_c;
        y_d      = y_pix_c;
        colour_d = fill_q;
        plot_d   = on_screen_c;
        busy_d   = 1'b1;
        if (last_c) begin
          state_d = FIN;
        end else begin
          advance_c = 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Self-checking bench for vga_rect_plotter (default 320x240, 3-bit colour) against a per-cycle behavioural model.
module tb_vga_rect_plotter;

  localparam int XW  = 9;
  localparam int YW  = 8;
  localparam int CW  = 3;
  localparam int SCW = 320;
  localparam int SCH = 240;

  logic          clock;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic [XW-1:0] req_w;
  logic [YW-1:0] req_h;
  logic [CW-1:0] req_colour;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          busy;
  logic          done;

  vga_rect_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int acc_cyc = -1;

  // Model of the command in flight, indexed by the edge number at which it was accepted.
  int active = 0;
  int n0 = 0, mx0 = 0, my0 = 0, mw = 0, mh = 0, mc = 0;
  int lx = 0, ly = 0, lc = 0;
  int mready = 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    int p, k, xs, ys, ex_plot, ex_busy, ex_done, ex_x, ex_y, ex_c;
    cyc++;
    if (!resetn) begin
      active = 0;
      lx = 0; ly = 0; lc = 0;
      mready = 1;
      chk("rst_plot", int'(plot), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(req_ready), 1);
    end else begin
      if (req_valid && (mready != 0)) begin
        active = 1;
        n0 = cyc; mx0 = int'(req_x); my0 = int'(req_y);
        mw = int'(req_w); mh = int'(req_h); mc = int'(req_colour);
        acc_cyc = cyc;
      end
      p = mw * mh;
      ex_plot = 0; ex_busy = 0; ex_done = 0;
      if ((active != 0) && (cyc >= n0 + 1) && (cyc <= n0 + p)) begin
        k  = cyc - n0 - 1;
        xs = mx0 + (k % mw);
        ys = my0 + (k / mw);
        lx = xs % (1 << XW);
        ly = ys % (1 << YW);
        lc = mc;
        ex_busy = 1;
`ifdef VGA_RECT_CLIP_EN
        ex_plot = ((xs < SCW) && (ys < SCH)) ? 1 : 0;
`else
        ex_plot = 1;
`endif
      end
      if ((active != 0) && (cyc == n0 + p + 1)) ex_done = 1;
      ex_x = lx; ex_y = ly; ex_c = lc;
      mready = ((active != 0) && (cyc >= n0) && (cyc <= n0 + p)) ? 0 : 1;
      chk("plot", int'(plot), ex_plot);
      chk("busy", int'(busy), ex_busy);
      chk("done", int'(done), ex_done);
      chk("x", int'(x), ex_x);
      chk("y", int'(y), ex_y);
      chk("colour", int'(colour), ex_c);
      chk("req_ready", int'(req_ready), mready);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int cx, input int cy, input int cw, input int ch, input int cc);
    bit got;
    got = 1'b0;
    tick();
    req_x = XW'(cx); req_y = YW'(cy); req_w = XW'(cw); req_h = YW'(ch); req_colour = CW'(cc);
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (acc_cyc == cyc) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_timeout", int'(got), 1);
    req_valid  = 1'b0;
    req_x      = XW'($urandom);
    req_y      = YW'($urandom);
    req_w      = XW'($urandom);
    req_h      = YW'($urandom);
    req_colour = CW'($urandom);
  endtask

  initial begin
    int lit_x[6];
    int lit_y[6];
    int ov_plot[4];
    int a1, a2;
    lit_x = '{10, 11, 12, 10, 11, 12};
    lit_y = '{20, 20, 20, 21, 21, 21};
`ifdef VGA_RECT_CLIP_EN
    ov_plot = '{1, 1, 0, 0};
`else
    ov_plot = '{1, 1, 1, 1};
`endif
    resetn = 1'b0; req_valid = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    idle(3);
    resetn = 1'b1;
    idle(10);

    // Basic fill, pinned with literal coordinates.
    send(10, 20, 3, 2, 5);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("basic_x", int'(x), lit_x[k]);
      chk("basic_y", int'(y), lit_y[k]);
      chk("basic_plot", int'(plot), 1);
      chk("basic_colour", int'(colour), 5);
      chk("basic_busy", int'(busy), 1);
    end
    tick();
    chk("basic_done", int'(done), 1);
    chk("basic_plot_end", int'(plot), 0);
    idle(2);

    // Empty rectangles: done one edge after accept, no plot.
    send(7, 7, 0, 5, 1);
    tick();
    chk("empty_w_done", int'(done), 1);
    chk("empty_w_plot", int'(plot), 0);
    send(7, 7, 4, 0, 2);
    tick();
    chk("empty_h_done", int'(done), 1);
    chk("empty_h_plot", int'(plot), 0);
    idle(2);

    // Second request held while busy: accepted only after FIN.
    send(100, 50, 5, 2, 6);
    a1 = acc_cyc;
    send(30, 40, 2, 2, 3);
    a2 = acc_cyc;
    chk("busy_accept_gap", a2 - a1, 12);
    idle(8);

    // Right-edge overflow.
    send(318, 0, 4, 1, 7);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ovf_x", int'(x), 318 + k);
      chk("ovf_plot", int'(plot), ov_plot[k]);
    end
    idle(3);

    // Abort after 5 of 12 pixels.
    send(50, 60, 4, 3, 2);
    idle(5);
    chk("abort_pre_plot", int'(plot), 1);
    resetn = 1'b0;
    #1;
    chk("abort_async_plot", int'(plot), 0);
    chk("abort_async_busy", int'(busy), 0);
    chk("abort_ready", int'(req_ready), 1);
    idle(3);
    resetn = 1'b1;
    idle(10);
    send(1, 2, 2, 2, 4);
    idle(8);

    // Randomized commands, biased toward the wrap/clip boundaries.
    for (int i = 0; i < 40; i++) begin
      int rx, ry;
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 511));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(230, 255)) : int'($urandom_range(0, 255));
      send(rx, ry, int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
    end
    idle(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
